scroll_window_ctrl: RTL and testbench

//  - Sequences the 16-nibble scrolling message shown on the four-digit LED display.
//  - Debounces the scroll button, keeps a wrap-around window offset and drives hex3..hex0.
//  - hex3..hex0 feed FourDigitLEDdriver directly; this block sits between the board inputs and that driver.

---
 rtl/scroll_window_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_scroll_window_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_window_ctrl.sv
// rtl/scroll_window_ctrl.sv - debounced scroll-window sequencer for the four-digit LED display
//
// Stores a 16-nibble message and shows a 4-nibble window of it on hex0..hex3.
// The window start (offset) wraps modulo 16. A debounced button press moves it
// one nibble in the direction given by dir.
// Optional feature macro: SCROLL_AUTO_EN adds auto_en and a periodic auto-scroll tick.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous reset, active low
//   button     - raw push-button (asynchronous, bouncy)
//   dir        - 0: offset+1, 1: offset-1
//   msg_load   - one-cycle strobe that captures message1/message2
//   message1   - nibbles 0..7 (message1[31:28] = nibble 0)
//   message2   - nibbles 8..15 (message2[31:28] = nibble 8)
//   auto_en    - auto-scroll enable (SCROLL_AUTO_EN only)
//   hex0..hex3 - nibbles offset, offset+1, offset+2, offset+3 (mod 16)
//   offset     - current window start nibble index
//   step_pulse - high for the one cycle in which a scroll step is taken
module scroll_window_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    input  logic        dir,
    input  logic        msg_load,
    input  logic [31:0] message1,
    input  logic [31:0] message2,
`ifdef SCROLL_AUTO_EN
    input  logic        auto_en,
`endif
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic [3:0]  offset,
    output logic        step_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || AUTO_PERIOD < 1) begin : g_param_check
        $error("scroll_window_ctrl: DEBOUNCE_CYCLES must be >= 2 and AUTO_PERIOD >= 1");
    end

    typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          sync1, btn_s;
    logic          btn_step;
    logic          any_step;
    logic [63:0]   msg_reg;

    // Two-flop synchroniser; only btn_s is used downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= button;
            btn_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A press must stay stable for DEBOUNCE_CYCLES synced cycles before it
    // steps. The release must also stay stable that long before a new press
    // can arm, so a held button steps only once.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        btn_step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = ARMING;
                    cnt_next   = '0;
                end
            end
            ARMING: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    btn_step   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = RELEASING;
                    cnt_next   = '0;
                end
            end
            RELEASING: begin
                if (btn_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef SCROLL_AUTO_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] auto_cnt;
    logic          auto_tick;

    assign auto_tick = auto_en && (auto_cnt == AUTO_MAX);

    // Any step or load restarts the period, so a button step followed by a
    // tick can never land closer together than AUTO_PERIOD cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt <= '0;
        end else if (msg_load || step_pulse || !auto_en) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AW'(1);
        end
    end

    assign any_step = btn_step | auto_tick;
`else
    assign any_step = btn_step;
`endif

    // A load wins over a step in the same cycle, so the step is suppressed
    // at the source rather than undone later.
    assign step_pulse = any_step & ~msg_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_reg <= 64'h0;
            offset  <= 4'h0;
        end else if (msg_load) begin
            msg_reg <= {message1, message2};
            offset  <= 4'h0;
        end else if (step_pulse) begin
            offset  <= dir ? (offset - 4'd1) : (offset + 4'd1);
        end
    end

    // Nibble k lives at msg_reg[63-4k -: 4]. The 4-bit index sum wraps
    // modulo 16 on its own.
    always_comb begin
        logic [3:0] idx [4];
        logic [5:0] lsb [4];
        logic [3:0] nib [4];
        for (int i = 0; i < 4; i++) begin
            idx[i] = offset + 4'(i);
            lsb[i] = 6'd60 - {idx[i], 2'b00};
            nib[i] = msg_reg[lsb[i] +: 4];
        end
        hex0 = nib[0];
        hex1 = nib[1];
        hex2 = nib[2];
        hex3 = nib[3];
    end

endmodule

// File: tb/tb_scroll_window_ctrl.sv
// tb/tb_scroll_window_ctrl.sv - directed self-checking bench for scroll_window_ctrl
module tb_scroll_window_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        button = 1'b0;
    logic        dir = 1'b0;
    logic        msg_load = 1'b0;
    logic [31:0] message1 = '0;
    logic [31:0] message2 = '0;
`ifdef SCROLL_AUTO_EN
    logic        auto_en = 1'b0;
`endif
    logic [3:0]  hex0, hex1, hex2, hex3, offset;
    logic        step_pulse;
    logic [15:0] win;

    int n_checks = 0;
    int n_errors = 0;

    assign win = {hex0, hex1, hex2, hex3};

    scroll_window_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
        .clk(clk),
        .reset(reset),
        .button(button),
        .dir(dir),
        .msg_load(msg_load),
        .message1(message1),
        .message2(message2),
`ifdef SCROLL_AUTO_EN
        .auto_en(auto_en),
`endif
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3),
        .offset(offset),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advances n cycles, sampling 1 time unit after each rising edge.
    task automatic run_count(input int n, output int pulses, output int first_k);
        pulses  = 0;
        first_k = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (step_pulse) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
    endtask

    task automatic press(input int hold, output int pulses, output int first_k);
        int p2, f2;
        button = 1'b1;
        run_count(hold, pulses, first_k);
        button = 1'b0;
        run_count(10, p2, f2);
        pulses += p2;
    endtask

    task automatic do_load(input logic [31:0] m1, input logic [31:0] m2);
        message1 = m1;
        message2 = m2;
        msg_load = 1'b1;
        @(posedge clk);
        #1;
        msg_load = 1'b0;
    endtask

    initial begin
        int p, f, found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_offset", offset, 4'h0);
        check_eq("reset_hex", win, 16'h0000);
        check_eq("reset_step", step_pulse, 1'b0);
        reset = 1'b1;

        // Mid-run async reset while a press is being qualified
        do_load(32'hFEDCBA98, 32'h76543210);
        press(8, p, f);
        check_eq("pre_reset_offset", offset, 4'h1);
        button = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("midreset_offset", offset, 4'h0);
        check_eq("midreset_hex", win, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_count(12, p, f);
        check_eq("requalify_pulses", p, 1);
        check_eq("requalify_latency", f, 6);
        button = 1'b0;
        run_count(10, p, f);

        // Load the reference message
        do_load(32'h01234567, 32'h89ABCDEF);
        check_eq("load_offset", offset, 4'h0);
        check_eq("load_hex", win, 16'h0123);

        // Clean press, held 50 cycles
        dir = 1'b0;
        press(50, p, f);
        check_eq("clean_pulses", p, 1);
        check_eq("clean_latency", f, 6);
        check_eq("clean_offset", offset, 4'h1);
        check_eq("clean_hex", win, 16'h1234);

        // Bounce: 3 high / 1 low, five times
        p = 0;
        repeat (5) begin
            int pp, ff;
            button = 1'b1;
            run_count(3, pp, ff);
            p += pp;
            button = 1'b0;
            run_count(1, pp, ff);
            p += pp;
        end
        run_count(10, f, found);
        p += f;
        check_eq("bounce_pulses", p, 0);
        check_eq("bounce_offset", offset, 4'h1);
        press(10, p, f);
        check_eq("after_bounce_pulses", p, 1);
        check_eq("after_bounce_offset", offset, 4'h2);

        // Wrap forward and backward
        do_load(32'h01234567, 32'h89ABCDEF);
        for (int i = 0; i < 15; i++) press(8, p, f);
        check_eq("wrap15_offset", offset, 4'hF);
        check_eq("wrap15_hex", win, 16'hF012);
        press(8, p, f);
        check_eq("wrap16_offset", offset, 4'h0);
        check_eq("wrap16_hex", win, 16'h0123);
        dir = 1'b1;
        press(8, p, f);
        check_eq("back_offset", offset, 4'hF);
        check_eq("back_hex", win, 16'hF012);

        // Load in the same cycle as step_pulse
        dir = 1'b0;
        button = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (step_pulse) found = 1;
        end
        check_eq("coload_found_step", found, 1);
        message1 = 32'hFEDCBA98;
        message2 = 32'h76543210;
        msg_load = 1'b1;
        #1;
        check_eq("coload_step_masked", step_pulse, 1'b0);
        @(posedge clk);
        #1;
        msg_load = 1'b0;
        check_eq("coload_offset", offset, 4'h0);
        check_eq("coload_hex", win, 16'hFEDC);
        run_count(10, p, f);
        button = 1'b0;
        run_count(10, f, found);
        check_eq("coload_no_repeat", p + f, 0);
        check_eq("coload_offset_hold", offset, 4'h0);

`ifdef SCROLL_AUTO_EN
        // Auto-scroll every 8 cycles
        do_load(32'h01234567, 32'h89ABCDEF);
        auto_en = 1'b1;
        p = 0;
        f = 0;
        found = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (step_pulse) begin
                p++;
                if (f == 0) f = k;
                else found = k;
            end
        end
        check_eq("auto_pulses", p, 2);
        check_eq("auto_first", f, 7);
        check_eq("auto_second", found, 15);
        check_eq("auto_offset", offset, 4'h2);

        // Button step coinciding with a tick
        auto_en = 1'b0;
        @(posedge clk);
        #1;
        auto_en = 1'b1;
        @(posedge clk);
        #1;
        button = 1'b1;
        run_count(7, p, f);
        check_eq("coinc_pulses", p, 1);
        check_eq("coinc_when", f, 6);
        check_eq("coinc_offset", offset, 4'h3);
        auto_en = 1'b0;
        button = 1'b0;
        run_count(20, p, f);
        check_eq("auto_off_pulses", p, 0);
        check_eq("auto_off_offset", offset, 4'h3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
